mux4_rr_arbiter: RTL

Round-robin arbiter that shares one 4:1 data multiplexer between four requesters. It tracks requests, issues a one-hot grant, and drives the mux select. It also presents the selected word on a valid/ready output port, and bounds each grant tenure to MAX_HOLD transfers. It sits directly in front of the shared `mux4` datapath and replaces any free-running select logic.

---
 rtl/mux4_arb_pkg.sv | 43 ++++
 rtl/mux4_rr_arbiter_mux4.sv | 30 +++
 rtl/mux4_rr_arbiter.sv | 133 +++++++++++++
 3 files changed

// File: rtl/mux4_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mux4_arb_pkg
// Brief    : Shared types, sizes and round-robin search helper for the
//            four-requester mux arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package mux4_arb_pkg;

    localparam int N_REQ = 4;
    localparam int IDX_W = 2;
    localparam int CNT_W = 8;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    typedef struct packed {
        logic             found;
        logic [IDX_W-1:0] idx;
    } pick_t;

    // First set request at or after 'start', wrapping modulo N_REQ.
    // The loop runs from the farthest offset down so the nearest one wins.
    function automatic pick_t rr_pick(input logic [N_REQ-1:0] req,
                                      input logic [IDX_W-1:0] start);
        pick_t            p;
        logic [IDX_W-1:0] cand;
        p.found = 1'b0;
        p.idx   = start;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            cand = start + IDX_W'(i);
            if (req[cand]) begin
                p.found = 1'b1;
                p.idx   = cand;
            end
        end
        return p;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mux4_rr_arbiter_mux4.sv
`default_nettype none
// ============================================================================
// Module   : mux4
// Brief    : Parameterized 4:1 data multiplexer shared by the arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module mux4 #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    input  logic [1:0]       sel,
    output logic [WIDTH-1:0] y
);

    // Pure select, no gating here; the arbiter owns validity.
    always_comb begin
        y = a;
        case (sel)
            2'd0:    y = a;
            2'd1:    y = b;
            2'd2:    y = c;
            default: y = d;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mux4_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mux4_rr_arbiter
// Brief    : Round-robin arbiter owning a shared 4:1 mux, presenting the
//            granted requester's word on a valid/ready port with a bounded
//            number of transfers per grant tenure.
// Revision : 1.0 - initial release
// ============================================================================
module mux4_rr_arbiter
    import mux4_arb_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int MAX_HOLD = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       req,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] y,
    output logic [3:0]       gnt,
    output logic [1:0]       sel
);

    localparam logic [CNT_W:0] HOLD_LIMIT = (CNT_W + 1)'(MAX_HOLD);

    state_t           state, state_nx;
    logic [1:0]       sel_nx;
    logic [3:0]       gnt_nx;
    logic [1:0]       ptr, ptr_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;

    logic             holder_req;
    logic             xfer;
    logic [CNT_W:0]   cnt_inc;
    logic             end_drop;
    logic             end_hold;
    logic [3:0]       rotate_req;
    pick_t            idle_pick;
    pick_t            rotate_pick;
    logic [WIDTH-1:0] mux_y;

    // Holder validity and tenure-end conditions, all combinational.
    always_comb begin
        holder_req  = req[sel];
        out_valid   = (state == GRANT) && holder_req;
        xfer        = out_valid && out_ready;
        cnt_inc     = {1'b0, cnt} + {{CNT_W{1'b0}}, 1'b1};
        end_drop    = (state == GRANT) && !holder_req;
        end_hold    = xfer && (cnt_inc == HOLD_LIMIT);
        // A dropped holder is masked; a holder ending on its limit may win again.
        rotate_req  = end_drop ? (req & ~gnt) : req;
        idle_pick   = rr_pick(req, ptr);
        rotate_pick = rr_pick(rotate_req, sel + 2'd1);
    end

    // Next-state and next-register logic for the two-state arbiter.
    always_comb begin
        state_nx = state;
        sel_nx   = sel;
        gnt_nx   = gnt;
        ptr_nx   = ptr;
        cnt_nx   = cnt;
        case (state)
            IDLE: begin
                if (idle_pick.found) begin
                    state_nx = GRANT;
                    sel_nx   = idle_pick.idx;
                    gnt_nx   = 4'b0001 << idle_pick.idx;
                    cnt_nx   = '0;
                end
            end
            GRANT: begin
                if (end_drop || end_hold) begin
                    ptr_nx = sel + 2'd1;
                    cnt_nx = '0;
                    if (rotate_pick.found) begin
                        sel_nx = rotate_pick.idx;
                        gnt_nx = 4'b0001 << rotate_pick.idx;
                    end else begin
                        state_nx = IDLE;
                        gnt_nx   = '0;
                    end
                end else if (xfer) begin
                    cnt_nx = cnt_inc[CNT_W-1:0];
                end
            end
            default: begin
                state_nx = IDLE;
                gnt_nx   = '0;
            end
        endcase
    end

    // Control state registers; reset aborts any tenure immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            sel   <= '0;
            gnt   <= '0;
            ptr   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            sel   <= sel_nx;
            gnt   <= gnt_nx;
            ptr   <= ptr_nx;
            cnt   <= cnt_nx;
        end
    end

    mux4 #(
        .WIDTH (WIDTH)
    ) u_mux4 (
        .a   (a),
        .b   (b),
        .c   (c),
        .d   (d),
        .sel (sel),
        .y   (mux_y)
    );

    // Output word is forced to zero whenever nothing valid is presented.
    always_comb begin
        y = out_valid ? mux_y : '0;
    end

endmodule
`default_nettype wire
